// File: rtl/hnoc_pkg.sv
// Shared packet layout, LFSR constants and saturating helpers for the HNoC PE endpoints.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package hnoc_pkg;

    localparam int PKT_W     = 32;
    localparam int DEST_MSB  = 31;
    localparam int DEST_LSB  = 24;
    localparam int PAYLOAD_W = 24;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hnoc_lfsr16.sv
// 16-bit Galois LFSR used to throttle the PE receive ready.
// State updates one edge after load/advance; no backpressure, free-running when advance is high.
// A zero seed would lock up the register, so it is replaced by the default seed.
module hnoc_lfsr16
    import hnoc_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (load) begin
            state <= (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/pe_rx_checker.sv
// Receive endpoint for one HNoC PE port: checks dest, range and per-source ordering, keeps counters.
// Two stages: capture at transfer edge k, decode/check and counter update at edge k+1; 1 pkt/cycle.
// Ready is a register (optionally LFSR-throttled) and never depends on valid.
module pe_rx_checker
    import hnoc_pkg::*;
#(
    parameter int ADDRESS   = 0,
    parameter int NUM_PE    = 8,
    parameter int PKT_LIMIT = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    input  logic        i_stall_en,
    input  logic [15:0] i_stall_seed,
    input  logic [31:0] i_expected,
    input  logic [7:0]  i_src_sel,
    output logic [15:0] o_src_count,
    output logic [31:0] o_rx_count,
    output logic [15:0] o_err_dest,
    output logic [15:0] o_err_range,
    output logic [15:0] o_err_order,
    output logic        o_err,
    output logic        o_done
);

    localparam logic [31:0] RANGE_LIM = 32'(NUM_PE * PKT_LIMIT);
    localparam logic [15:0] READY_TAP = 16'h0001;

    logic [15:0] lfsr_state;

    hnoc_lfsr16 u_lfsr (
        .clk     (clk),
        .load    (~rst),
        .seed    (i_stall_seed),
        .advance (1'b1),
        .state   (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_data_ready <= 1'b0;
        end else begin
            o_data_ready <= ~i_stall_en | ((lfsr_state & READY_TAP) != 16'd0);
        end
    end

    logic xfer;
    assign xfer = i_data_valid & o_data_ready;

    logic              s1_vld;
    logic [PKT_W-1:0]  s1_dat;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= xfer;
            if (xfer) begin
                s1_dat <= i_data;
            end
        end
    end

    logic [7:0]           dest;
    logic [31:0]          pl32;
    logic [7:0]           src;
    logic [31:0]          base;
    logic [PAYLOAD_W-1:0] seq_num;
    logic                 dest_fail;
    logic                 range_fail;
    logic                 order_fail;
    logic [PAYLOAD_W-1:0] cur_last;
    logic                 cur_vld;

    logic [PAYLOAD_W-1:0] last_seq [NUM_PE];
    logic [NUM_PE-1:0]    seq_vld;
    logic [15:0]          src_cnt  [NUM_PE];

    assign dest = s1_dat[DEST_MSB:DEST_LSB];
    assign pl32 = {8'd0, s1_dat[PAYLOAD_W-1:0]};

    // Source decode by comparator chain: the last threshold the payload clears wins.
    always_comb begin
        src  = '0;
        base = '0;
        for (int s = 1; s < NUM_PE; s++) begin
            if (pl32 >= 32'(s * PKT_LIMIT)) begin
                src  = 8'(s);
                base = 32'(s * PKT_LIMIT);
            end
        end
    end

    assign seq_num    = PAYLOAD_W'(pl32 - base);
    assign dest_fail  = (dest != 8'(ADDRESS));
    assign range_fail = (pl32 >= RANGE_LIM);

    always_comb begin
        cur_last = '0;
        cur_vld  = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (src == 8'(i)) begin
                cur_last = last_seq[i];
                cur_vld  = seq_vld[i];
            end
        end
    end

    assign order_fail = ~range_fail & cur_vld & (seq_num <= cur_last);

    logic [31:0] rx_nxt;
    assign rx_nxt = s1_vld ? sat_inc32(o_rx_count) : o_rx_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_rx_count  <= '0;
            o_err_dest  <= '0;
            o_err_range <= '0;
            o_err_order <= '0;
            o_err       <= 1'b0;
            o_done      <= 1'b0;
            seq_vld     <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                last_seq[i] <= '0;
                src_cnt[i]  <= '0;
            end
        end else begin
            o_rx_count <= rx_nxt;
            if ((i_expected != 32'd0) && (rx_nxt == i_expected)) begin
                o_done <= 1'b1;
            end
            if (s1_vld) begin
                if (dest_fail) begin
                    o_err_dest <= sat_inc16(o_err_dest);
                end
                if (range_fail) begin
                    o_err_range <= sat_inc16(o_err_range);
                end
                if (order_fail) begin
                    o_err_order <= sat_inc16(o_err_order);
                end
                if (dest_fail | range_fail | order_fail) begin
                    o_err <= 1'b1;
                end
                // Gaps are legal: only a non-increasing sequence is flagged.
                for (int i = 0; i < NUM_PE; i++) begin
                    if (!range_fail && (src == 8'(i))) begin
                        src_cnt[i] <= sat_inc16(src_cnt[i]);
                        if (!order_fail) begin
                            last_seq[i] <= seq_num;
                            seq_vld[i]  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        o_src_count = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (i_src_sel == 8'(i)) begin
                o_src_count = src_cnt[i];
            end
        end
    end

endmodule

// File: tb/tb_pe_rx_checker.sv
// Directed bench for pe_rx_checker (ADDRESS=3, NUM_PE=8, PKT_LIMIT=100).
module tb_pe_rx_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_data_valid = 1'b0;
    logic        o_data_ready;
    logic        i_stall_en = 1'b0;
    logic [15:0] i_stall_seed = '0;
    logic [31:0] i_expected = '0;
    logic [7:0]  i_src_sel = '0;
    logic [15:0] o_src_count;
    logic [31:0] o_rx_count;
    logic [15:0] o_err_dest;
    logic [15:0] o_err_range;
    logic [15:0] o_err_order;
    logic        o_err;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_rx_checker #(.ADDRESS(3), .NUM_PE(8), .PKT_LIMIT(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .i_stall_en   (i_stall_en),
        .i_stall_seed (i_stall_seed),
        .i_expected   (i_expected),
        .i_src_sel    (i_src_sel),
        .o_src_count  (o_src_count),
        .o_rx_count   (o_rx_count),
        .o_err_dest   (o_err_dest),
        .o_err_range  (o_err_range),
        .o_err_order  (o_err_order),
        .o_err        (o_err),
        .o_done       (o_done)
    );

    typedef struct {
        bit          rst_first;
        logic [31:0] data;
        logic [7:0]  sel;
        logic [31:0] rx;
        logic [15:0] ed;
        logic [15:0] er;
        logic [15:0] eo;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic logic [31:0] pkt(input int dest, input int pl);
        return {8'(dest), 24'(pl)};
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("ready_in_reset", {31'd0, o_data_ready}, 32'd0);
        chk("rx_in_reset", o_rx_count, 32'd0);
        rst = 1'b1;
    endtask

    task automatic send(input logic [31:0] d);
        @(negedge clk);
        i_data = d;
        i_data_valid = 1'b1;
        @(negedge clk);
        i_data_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_stall(input logic [15:0] seed, input int cycles);
        logic [15:0] m;
        logic        exp_rdy;
        int          sent;
        int          sum;
        i_stall_en   = 1'b1;
        i_stall_seed = seed;
        do_reset();
        m    = (seed == 16'd0) ? 16'hACE1 : seed;
        sent = 0;
        i_data = pkt(3, 0);
        i_data_valid = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            i_data  = pkt(3, sent);
            exp_rdy = m[0];
            m       = ref_step(m);
            chk("stall_ready", {31'd0, o_data_ready}, {31'd0, exp_rdy});
            if (exp_rdy) sent++;
        end
        i_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_rx", o_rx_count, 32'(sent));
        chk("stall_err", {31'd0, o_err}, 32'd0);
        sum = 0;
        for (int s = 0; s < 8; s++) begin
            i_src_sel = 8'(s);
            #1;
            sum += int'(o_src_count);
        end
        chk("stall_src_sum", 32'(sum), 32'(sent));
        i_stall_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               rst   data          sel  rx  ed  er  eo  cnt err
        vecs[0]  = '{1'b1, pkt(3, 310), 8'd3, 1, 0, 0, 0, 1, 1'b0};
        vecs[1]  = '{1'b0, pkt(3, 305), 8'd3, 2, 0, 0, 1, 2, 1'b1};
        vecs[2]  = '{1'b1, pkt(3, 310), 8'd3, 1, 0, 0, 0, 1, 1'b0};
        vecs[3]  = '{1'b0, pkt(3, 315), 8'd3, 2, 0, 0, 0, 2, 1'b0};
        vecs[4]  = '{1'b0, pkt(3, 310), 8'd3, 3, 0, 0, 1, 3, 1'b1};
        vecs[5]  = '{1'b1, pkt(5, 205), 8'd2, 1, 1, 0, 0, 1, 1'b1};
        vecs[6]  = '{1'b1, pkt(3, 800), 8'd0, 1, 0, 1, 0, 0, 1'b1};
        vecs[7]  = '{1'b0, pkt(3, 799), 8'd7, 2, 0, 1, 0, 1, 1'b1};
        vecs[8]  = '{1'b0, pkt(3, 0),   8'd0, 3, 0, 1, 0, 1, 1'b1};
        vecs[9]  = '{1'b0, pkt(3, 100), 8'd8, 4, 0, 1, 0, 0, 1'b1};
        vecs[10] = '{1'b1, pkt(3, 399), 8'd3, 1, 0, 0, 0, 1, 1'b0};
        vecs[11] = '{1'b0, pkt(3, 400), 8'd3, 2, 0, 0, 0, 1, 1'b0};
        vecs[12] = '{1'b0, pkt(3, 400), 8'd4, 3, 0, 0, 1, 2, 1'b1};
        vecs[13] = '{1'b1, pkt(9, 900), 8'd0, 1, 1, 1, 0, 0, 1'b1};

        // Back-to-back packets from source 1 with stall disabled.
        do_reset();
        @(negedge clk);
        chk("ready_after_release", {31'd0, o_data_ready}, 32'd1);
        for (int p = 0; p < 3; p++) begin
            i_data = pkt(3, 100 + p);
            i_data_valid = 1'b1;
            @(negedge clk);
            chk("ready_held", {31'd0, o_data_ready}, 32'd1);
        end
        i_data_valid = 1'b0;
        @(negedge clk);
        i_src_sel = 8'd1;
        #1;
        chk("b2b_rx", o_rx_count, 32'd3);
        chk("b2b_src1", {16'd0, o_src_count}, 32'd3);
        chk("b2b_errs", {16'd0, o_err_dest | o_err_range | o_err_order}, 32'd0);
        chk("b2b_err", {31'd0, o_err}, 32'd0);

        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].rst_first) do_reset();
            i_src_sel = vecs[v].sel;
            send(vecs[v].data);
            chk($sformatf("v%0d_rx", v), o_rx_count, vecs[v].rx);
            chk($sformatf("v%0d_err_dest", v), {16'd0, o_err_dest}, {16'd0, vecs[v].ed});
            chk($sformatf("v%0d_err_range", v), {16'd0, o_err_range}, {16'd0, vecs[v].er});
            chk($sformatf("v%0d_err_order", v), {16'd0, o_err_order}, {16'd0, vecs[v].eo});
            chk($sformatf("v%0d_src_count", v), {16'd0, o_src_count}, {16'd0, vecs[v].cnt});
            chk($sformatf("v%0d_err", v), {31'd0, o_err}, {31'd0, vecs[v].err});
        end

        // Done flag, then reset with a packet sitting in the capture stage.
        i_expected = 32'd4;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            i_data = pkt(3, 100 + p);
            i_data_valid = 1'b1;
        end
        @(negedge clk);
        i_data_valid = 1'b0;
        chk("done_early_rx", o_rx_count, 32'd3);
        chk("done_early", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        chk("done_rx", o_rx_count, 32'd4);
        chk("done_set", {31'd0, o_done}, 32'd1);
        i_data = pkt(5, 104);
        i_data_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_data_valid = 1'b0;
        @(negedge clk);
        i_src_sel = 8'd1;
        #1;
        chk("midrst_rx", o_rx_count, 32'd0);
        chk("midrst_done", {31'd0, o_done}, 32'd0);
        chk("midrst_err", {31'd0, o_err}, 32'd0);
        chk("midrst_dest", {16'd0, o_err_dest}, 32'd0);
        chk("midrst_ready", {31'd0, o_data_ready}, 32'd0);
        chk("midrst_src1", {16'd0, o_src_count}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_flushed_rx", o_rx_count, 32'd0);
        chk("midrst_flushed_dest", {16'd0, o_err_dest}, 32'd0);
        i_expected = 32'd0;

        // LFSR-throttled ready, including the zero-seed substitution.
        run_stall(16'h0001, 500);
        run_stall(16'h0000, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
